inference_scheduler: RTL

Round-robin scheduler that shares the single classifier engine among up to `NUM_CH` sensor channels. A programmable period timer starts a scan round. Each round visits every enabled channel that has a full sample window, starts one classification on it, and waits for the result. The block forwards each result, tagged with its channel, as a one-cycle pulse that drives the alarm logic's `classification_done`, `class_id` and `confidence` inputs.

---
 rtl/inference_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/inference_scheduler.sv
// inference_scheduler: round-robin scheduler sharing one classifier engine
// among NUM_CH sensor channels. A programmable period timer launches scan
// rounds; each round starts one classification per enabled, ready channel and
// forwards the tagged result as a one-cycle pulse.
// Optional feature: define SCHED_TIMEOUT_EN to enable the WAIT_DONE watchdog
// (abandons a classification after TIMEOUT_CYCLES and pulses timeout_err).
module inference_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CH_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [15:0]       period,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] window_ready,
  output logic [NUM_CH-1:0] window_ack,
  output logic              cls_start,
  output logic [CH_W-1:0]   cls_ch,
  input  logic              cls_done,
  input  logic [1:0]        cls_class_id,
  input  logic [7:0]        cls_confidence,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [1:0]        res_class_id,
  output logic [7:0]        res_confidence,
  output logic              timeout_err,
  output logic              tick_overrun,
  output logic              sched_busy,
  output logic [7:0]        round_count
);

  if (NUM_CH < 2 || NUM_CH > 8 || CH_W != $clog2(NUM_CH) || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("inference_scheduler: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    SELECT,
    START,
    WAIT_DONE,
    REPORT
  } state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] ptr, ptr_nxt;
  logic [15:0]     per_cnt;
  logic            tick;
  logic            pending;
  logic            pend_clr;
  logic            round_inc;
  logic            last_ch;
  logic            sel_hit;
  logic            done_ok;
  logic            timeout_hit;

  assign last_ch = (ptr == CH_W'(NUM_CH - 1));
  assign sel_hit = ch_mask[ptr] & window_ready[ptr];
  assign done_ok = (state == WAIT_DONE) && cls_done;

  // Round tick: counter free-runs while enabled and out of IDLE; >= compare
  // keeps a shrunk period from letting the counter run past its target.
  assign tick = enable && (state != IDLE) &&
                ((period <= 16'd1) || (per_cnt >= (period - 16'd1)));

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Watchdog: counts cycles spent in WAIT_DONE, restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // A result arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT_DONE) && !cls_done &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Period counter: held at zero while disabled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!enable || (state == IDLE) || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 16'd1;
    end
  end

  // Pending-round flag and sticky overrun; a tick coinciding with the flag
  // being consumed re-arms it instead of counting as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      if (!enable) begin
        pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
        if (pending && !pend_clr) begin
          tick_overrun <= 1'b1;
        end
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
    end
  end

  // FSM state and channel pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic: channel scan, classification handshake, enable drop.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    pend_clr  = 1'b0;
    round_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else if (pending) begin
          state_nxt = SELECT;
          ptr_nxt   = '0;
          pend_clr  = 1'b1;
        end
      end
      SELECT: begin
        if (!enable) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else if (sel_hit) begin
          state_nxt = START;
        end else if (last_ch) begin
          state_nxt = WAIT_TICK;
          ptr_nxt   = '0;
          round_inc = 1'b1;
        end else begin
          ptr_nxt = ptr + CH_W'(1);
        end
      end
      START: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE, REPORT: begin
        if ((state == WAIT_DONE) && cls_done) begin
          state_nxt = REPORT;
        end else if ((state == REPORT) || timeout_hit) begin
          // Channel finished (reported or abandoned): advance or leave.
          round_inc = last_ch;
          if (!enable) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
          end else if (last_ch) begin
            state_nxt = WAIT_TICK;
            ptr_nxt   = '0;
          end else begin
            state_nxt = SELECT;
            ptr_nxt   = ptr + CH_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Start pulse, one-hot window acknowledge and busy flag decode from state.
  always_comb begin
    window_ack = '0;
    cls_start  = (state == START);
    sched_busy = (state == SELECT) || (state == START) ||
                 (state == WAIT_DONE) || (state == REPORT);
    if (state == START) begin
      window_ack[ptr] = 1'b1;
    end
  end

  // Channel tag, result capture, error pulse and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_ch         <= '0;
      res_valid      <= 1'b0;
      res_ch         <= '0;
      res_class_id   <= '0;
      res_confidence <= '0;
      timeout_err    <= 1'b0;
      round_count    <= '0;
    end else begin
      res_valid   <= done_ok;
      timeout_err <= timeout_hit;
      if ((state == SELECT) && enable && sel_hit) begin
        cls_ch <= ptr;
      end
      if (done_ok) begin
        res_ch         <= cls_ch;
        res_class_id   <= cls_class_id;
        res_confidence <= cls_confidence;
      end
      if (round_inc) begin
        round_count <= round_count + 8'd1;
      end
    end
  end

endmodule
